// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared widths, size masks and FSM encodings for the
// memory-access stage.
//   MA_DATA_W / MA_REG_AW / MA_SEL_W : default data, reg-address, sel widths
//   SEL_BYTE / SEL_HALF / SEL_WORD   : size masks relative to lane 0
//   ST_IDLE / ST_WAIT                : RAM handshake FSM states
//   is_misaligned()                  : size/offset alignment rule
package mem_access_pkg;

    localparam int MA_DATA_W = 32;
    localparam int MA_REG_AW = 5;
    localparam int MA_SEL_W  = 4;

    localparam logic [3:0] SEL_BYTE = 4'b0001;
    localparam logic [3:0] SEL_HALF = 4'b0011;
    localparam logic [3:0] SEL_WORD = 4'b1111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Halfwords need an even address, words a 4-byte aligned one; bytes
    // are always aligned.
    function automatic logic is_misaligned(input logic [3:0] sel,
                                           input logic [1:0] addr_lo);
        return ((sel == SEL_HALF) && addr_lo[0]) ||
               ((sel == SEL_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// mem_load_align: combinational load formatter.
//   rdata     in  raw word from the data RAM
//   addr      in  byte offset within the word
//   sel       in  access size mask (byte / half / word)
//   sign_ext  in  1 = sign-extend, 0 = zero-extend
//   load_data out lane-selected, right-justified, extended value
module mem_load_align
    import mem_access_pkg::*;
#(
    parameter int DATA_W = MA_DATA_W,
    parameter int SEL_W  = MA_SEL_W
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        addr,
    input  logic [SEL_W-1:0]  sel,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] load_data
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        // Move the addressed lane down to bit 0 before extending.
        shifted = rdata >> {addr, 3'b000};
        case (sel)
            SEL_BYTE: load_data = {{(DATA_W-8){sign_ext & shifted[7]}}, shifted[7:0]};
            SEL_HALF: load_data = {{(DATA_W-16){sign_ext & shifted[15]}}, shifted[15:0]};
            default:  load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage behind execute.
//   clk, rst (async, active-high), flush      : control
//   mem_read/write/sign_ext_flag, mem_sel      : memory op description
//   mem_write_data, ex_result                  : store data, ALU result / address
//   reg_write_en/addr, current_pc_addr         : forwarded from execute
//   stall_req, addr_err                        : pipeline hold, misalignment flag
//   ram_en/we/addr/wdata, ram_rdata/ready      : data-RAM request/ready handshake
//   wb_result, wb_reg_write_en/addr, wb_pc_addr: write-back outputs
module mem_access
    import mem_access_pkg::*;
#(
    parameter int DATA_W = MA_DATA_W,
    parameter int REG_AW = MA_REG_AW,
    parameter int SEL_W  = MA_SEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              mem_read_flag,
    input  logic              mem_write_flag,
    input  logic              mem_sign_ext_flag,
    input  logic [SEL_W-1:0]  mem_sel,
    input  logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              reg_write_en,
    input  logic [REG_AW-1:0] reg_write_addr,
    input  logic [DATA_W-1:0] current_pc_addr,
    output logic              stall_req,
    output logic              addr_err,
    output logic              ram_en,
    output logic [SEL_W-1:0]  ram_we,
    output logic [DATA_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready,
    output logic [DATA_W-1:0] wb_result,
    output logic              wb_reg_write_en,
    output logic [REG_AW-1:0] wb_reg_write_addr,
    output logic [DATA_W-1:0] wb_pc_addr
);

    // Store data replicated across every lane of its size, so the RAM only
    // needs the lane enables to place it.
    function automatic logic [DATA_W-1:0] replicate_store(input logic [DATA_W-1:0] d,
                                                          input logic [SEL_W-1:0]  s);
        case (s)
            SEL_BYTE: return {(DATA_W/8){d[7:0]}};
            SEL_HALF: return {(DATA_W/16){d[15:0]}};
            default:  return d;
        endcase
    endfunction

    logic              valid_q,     valid_d;
    logic              read_q,      read_d;
    logic              write_q,     write_d;
    logic              sext_q,      sext_d;
    logic [SEL_W-1:0]  sel_q,       sel_d;
    logic              reg_we_q,    reg_we_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic [DATA_W-1:0] addr_q,      addr_d;
    logic [REG_AW-1:0] reg_waddr_q, reg_waddr_d;
    logic [DATA_W-1:0] pc_q,        pc_d;
    logic [0:0]        state_q,     state_d;

    logic              in_wait;
    logic              ram_ack;
    logic              misaligned;
    logic              in_mem_ok;
    logic [SEL_W-1:0]  lane_mask;
    logic [DATA_W-1:0] load_data;

    assign in_wait    = (state_q == ST_WAIT);
    // A ready pulse only counts while a request is actually outstanding.
    assign ram_ack    = in_wait & ram_ready;
    assign stall_req  = in_wait & ~ram_ready;
    assign misaligned = valid_q & (read_q | write_q) & is_misaligned(sel_q, addr_q[1:0]);
    // Entering op needs the RAM: not flushed, a load/store, and aligned.
    assign in_mem_ok  = ~flush & (mem_read_flag | mem_write_flag)
                      & ~is_misaligned(mem_sel, ex_result[1:0]);
    assign lane_mask  = sel_q << addr_q[1:0];

    always_comb begin
        valid_d     = valid_q;
        read_d      = read_q;
        write_d     = write_q;
        sext_d      = sext_q;
        sel_d       = sel_q;
        reg_we_d    = reg_we_q;
        wdata_d     = wdata_q;
        addr_d      = addr_q;
        reg_waddr_d = reg_waddr_q;
        pc_d        = pc_q;
        if (!stall_req) begin
            valid_d     = ~flush;
            read_d      = mem_read_flag;
            write_d     = mem_write_flag;
            sext_d      = mem_sign_ext_flag;
            sel_d       = mem_sel;
            reg_we_d    = reg_write_en;
            wdata_d     = mem_write_data;
            addr_d      = ex_result;
            reg_waddr_d = reg_write_addr;
            pc_d        = current_pc_addr;
        end
        // Stay in WAIT while stalled; on any loading edge (including the
        // completing one) go to WAIT only if the new op needs the RAM, so
        // back-to-back accesses chain without an idle cycle.
        state_d = (stall_req | in_mem_ok) ? ST_WAIT : ST_IDLE;
    end

    // ---- stage register: control ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            sext_q   <= 1'b0;
            sel_q    <= '0;
            reg_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            read_q   <= read_d;
            write_q  <= write_d;
            sext_q   <= sext_d;
            sel_q    <= sel_d;
            reg_we_q <= reg_we_d;
        end
    end

    // ---- stage register: data (qualified by valid_q, no reset needed) ----
    always_ff @(posedge clk) begin
        wdata_q     <= wdata_d;
        addr_q      <= addr_d;
        reg_waddr_q <= reg_waddr_d;
        pc_q        <= pc_d;
    end

    mem_load_align #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_load_align (
        .rdata     (ram_rdata),
        .addr      (addr_q[1:0]),
        .sel       (sel_q),
        .sign_ext  (sext_q),
        .load_data (load_data)
    );

    // RAM request fields are driven from the frozen stage register, so they
    // hold steady for the whole WAIT period and read as zero otherwise.
    assign ram_en    = in_wait;
    assign ram_we    = (in_wait & write_q) ? lane_mask : '0;
    assign ram_addr  = in_wait ? {addr_q[DATA_W-1:2], 2'b00} : '0;
    assign ram_wdata = in_wait ? replicate_store(wdata_q, sel_q) : '0;

    assign addr_err          = misaligned;
    assign wb_result         = read_q ? load_data : addr_q;
    assign wb_reg_write_en   = valid_q & reg_we_q & ~write_q & ~misaligned & ~stall_req
                             & (~read_q | ram_ack);
    assign wb_reg_write_addr = reg_waddr_q;
    assign wb_pc_addr        = pc_q;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        mem_read_flag = 1'b0;
    logic        mem_write_flag = 1'b0;
    logic        mem_sign_ext_flag = 1'b0;
    logic [3:0]  mem_sel = 4'h0;
    logic [31:0] mem_write_data = 32'h0;
    logic [31:0] ex_result = 32'h0;
    logic        reg_write_en = 1'b0;
    logic [4:0]  reg_write_addr = 5'h0;
    logic [31:0] current_pc_addr = 32'h0;
    logic        stall_req, addr_err, ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic        ram_ready = 1'b0;
    logic [31:0] wb_result;
    logic        wb_reg_write_en;
    logic [4:0]  wb_reg_write_addr;
    logic [31:0] wb_pc_addr;

    always #5 clk = ~clk;

    mem_access u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
        .mem_sign_ext_flag(mem_sign_ext_flag), .mem_sel(mem_sel),
        .mem_write_data(mem_write_data), .ex_result(ex_result),
        .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr),
        .current_pc_addr(current_pc_addr),
        .stall_req(stall_req), .addr_err(addr_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ready(ram_ready),
        .wb_result(wb_result), .wb_reg_write_en(wb_reg_write_en),
        .wb_reg_write_addr(wb_reg_write_addr), .wb_pc_addr(wb_pc_addr)
    );

    typedef struct {
        bit        rd, wr, sx;
        bit [3:0]  sel;
        bit [31:0] wd, a;
        bit        we;
        bit [4:0]  wa;
        bit [31:0] pc;
    } op_t;
    typedef struct { bit [31:0] res; bit [4:0] wa; bit [31:0] pc; } wb_t;
    typedef struct { bit [31:0] addr; bit [3:0] we; bit [31:0] wdata; int lat; bit [31:0] rdata; } ram_t;

    wb_t  wbq[$];
    ram_t ramq[$];
    int   checks = 0;
    int   errors = 0;
    bit   mw = 1'b0;      // model: RAM access outstanding
    bit   m_mis = 1'b0;   // model: misaligned op held in the stage
    int   stall_cycles = 0;
    int   waitc = 0;
    int   cur_lat = 0;
    bit [31:0] cur_rdata = 32'h0;

    task automatic check(input string name, input bit [31:0] act, input bit [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit mis_rule(input bit rd, input bit wr, input bit [3:0] sel, input bit [31:0] a);
        return (rd || wr) && ((sel == 4'h3 && a[0]) || (sel == 4'hF && a[1:0] != 2'b00));
    endfunction

    // Load value from the byte offset, sized and extended arithmetically.
    function automatic bit [31:0] fmt_load(input bit [31:0] rd, input bit [1:0] off,
                                           input bit [3:0] sel, input bit sx);
        bit [31:0] v;
        v = rd >> (8 * off);
        if (sel == 4'h1) begin
            v = v % 256;
            if (sx && v >= 128) v = v - 256;
        end else if (sel == 4'h3) begin
            v = v % 65536;
            if (sx && v >= 32768) v = v - 65536;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic op_t mk(input bit rd, input bit wr, input bit sx, input bit [3:0] sel,
                               input bit [31:0] wd, input bit [31:0] a, input bit we,
                               input bit [4:0] wa, input bit [31:0] pc);
        op_t o;
        o.rd = rd; o.wr = wr; o.sx = sx; o.sel = sel; o.wd = wd; o.a = a;
        o.we = we; o.wa = wa; o.pc = pc;
        return o;
    endfunction

    task automatic drive_nop();
        flush = 1'b0; mem_read_flag = 1'b0; mem_write_flag = 1'b0; mem_sign_ext_flag = 1'b0;
        mem_sel = 4'h0; mem_write_data = 32'h0; ex_result = 32'h0;
        reg_write_en = 1'b0; reg_write_addr = 5'h0; current_pc_addr = 32'h0;
    endtask

    // Asserts reset in the middle of a cycle and clears the bench model.
    task automatic pulse_reset_begin();
        @(negedge clk);
        #2;
        rst = 1'b1;
        mw = 1'b0; m_mis = 1'b0; waitc = 0;
        wbq.delete(); ramq.delete();
        drive_nop();
    endtask

    task automatic issue(input op_t o, input bit fl, input int lat, input bit [31:0] rdat);
        int  n;
        bit  cap;
        bit  tmo;
        n = 0; tmo = 1'b0;
        @(negedge clk);
        flush = fl; mem_read_flag = o.rd; mem_write_flag = o.wr; mem_sign_ext_flag = o.sx;
        mem_sel = o.sel; mem_write_data = o.wd; ex_result = o.a;
        reg_write_en = o.we; reg_write_addr = o.wa; current_pc_addr = o.pc;
        cur_lat = lat; cur_rdata = rdat;
        forever begin
            #4;
            cap = !(mw && !ram_ready);
            @(posedge clk);
            if (cap) break;
            n++;
            if (n > 100) begin tmo = 1'b1; break; end
            @(negedge clk);
        end
        #1;
        drive_nop();
        if (tmo) begin
            checks++; errors++;
            $display("FAIL issue_timeout: op at addr %h never captured within 100 cycles", o.a);
            pulse_reset_begin();
            @(negedge clk);
            #1 rst = 1'b0;
        end
    endtask

    // Reference model: tracks what the stage holds on every loading edge.
    initial begin
        bit c, s_rst, s_fl, mis;
        op_t s;
        int s_lat;
        bit [31:0] s_rdat;
        ram_t r;
        wb_t w;
        forever begin
            @(negedge clk);
            #4;
            c = !(mw && !ram_ready);
            s_rst = rst; s_fl = flush;
            s = mk(mem_read_flag, mem_write_flag, mem_sign_ext_flag, mem_sel, mem_write_data,
                   ex_result, reg_write_en, reg_write_addr, current_pc_addr);
            s_lat = cur_lat; s_rdat = cur_rdata;
            @(posedge clk);
            if (s_rst || rst || !c) continue;
            if (mw && ram_ready) mw = 1'b0;
            mis = mis_rule(s.rd, s.wr, s.sel, s.a);
            m_mis = !s_fl && mis;
            if (!s_fl && (s.rd || s.wr) && !mis) begin
                mw = 1'b1;
                r.addr  = s.a - (s.a % 4);
                r.we    = s.wr ? 4'(s.sel << s.a[1:0]) : 4'h0;
                r.wdata = (s.sel == 4'h1) ? (s.wd % 256) * 32'h01010101 :
                          (s.sel == 4'h3) ? (s.wd % 65536) * 32'h00010001 : s.wd;
                r.lat   = s_lat;
                r.rdata = s_rdat;
                ramq.push_back(r);
            end
            if (!s_fl && s.we && !s.wr && !mis) begin
                w.res = s.rd ? fmt_load(s_rdat, s.a[1:0], s.sel, s.sx) : s.a;
                w.wa  = s.wa;
                w.pc  = s.pc;
                wbq.push_back(w);
            end
        end
    end

    // Data-RAM responder: checks the request and completes it after lat waits.
    initial begin
        forever begin
            @(negedge clk);
            ram_ready = 1'b0;
            ram_rdata = $urandom;
            if (ram_en && !rst) begin
                if (ramq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ram_request: unexpected request addr %h", ram_addr);
                end else begin
                    check("ram_addr", ram_addr, ramq[0].addr);
                    check("ram_we", 32'(ram_we), 32'(ramq[0].we));
                    check("ram_wdata", ram_wdata, ramq[0].wdata);
                    if (waitc >= ramq[0].lat) begin
                        ram_ready = 1'b1;
                        ram_rdata = ramq[0].rdata;
                        void'(ramq.pop_front());
                        waitc = 0;
                    end else begin
                        waitc++;
                    end
                end
            end
        end
    end

    // Monitor: per-cycle control checks and write-back scoreboard.
    initial begin
        wb_t w;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                check("stall_req", 32'(stall_req), 32'(mw && !ram_ready));
                check("ram_en", 32'(ram_en), 32'(mw));
                check("addr_err", 32'(addr_err), 32'(m_mis));
                if (!ram_en)
                    check("ram_idle_zero", 32'(ram_we == 4'h0 && ram_addr == 32'h0 && ram_wdata == 32'h0), 32'd1);
                if (stall_req) stall_cycles++;
                if (wb_reg_write_en) begin
                    if (wbq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wb_unexpected: write to r%0d data %h with none expected",
                                 wb_reg_write_addr, wb_result);
                    end else begin
                        w = wbq.pop_front();
                        check("wb_result", wb_result, w.res);
                        check("wb_reg_write_addr", 32'(wb_reg_write_addr), 32'(w.wa));
                        check("wb_pc_addr", wb_pc_addr, w.pc);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t o;
        bit [3:0] sel;
        bit [31:0] a;
        int kind;
        drive_nop();
        rst = 1'b1;
        #2;
        check("reset_ram_en", 32'(ram_en), 32'd0);
        check("reset_stall_req", 32'(stall_req), 32'd0);
        check("reset_addr_err", 32'(addr_err), 32'd0);
        check("reset_wb_en", 32'(wb_reg_write_en), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;

        // ALU op
        issue(mk(0, 0, 0, 4'h0, 32'h0, 32'h12345678, 1, 5'd5, 32'h1000), 0, 0, 32'h0);
        repeat (2) @(negedge clk);

        // word load, zero wait states
        stall_cycles = 0;
        issue(mk(1, 0, 0, 4'hF, 32'h0, 32'h100, 1, 5'd7, 32'h1004), 0, 0, 32'hDEADBEEF);
        repeat (4) @(negedge clk);
        check("zero_wait_stalls", 32'(stall_cycles), 32'd0);

        // signed byte load, 3 wait states
        stall_cycles = 0;
        issue(mk(1, 0, 1, 4'h1, 32'h0, 32'h103, 1, 5'd8, 32'h1008), 0, 3, 32'h80FF0000);
        repeat (7) @(negedge clk);
        check("three_wait_stalls", 32'(stall_cycles), 32'd3);
        issue(mk(1, 0, 0, 4'h1, 32'h0, 32'h103, 1, 5'd9, 32'h100C), 0, 3, 32'h80FF0000);

        // half store
        issue(mk(0, 1, 0, 4'h3, 32'h0000ABCD, 32'h202, 1, 5'd10, 32'h1010), 0, 1, 32'h0);

        // misaligned word load
        issue(mk(1, 0, 0, 4'hF, 32'h0, 32'h101, 1, 5'd11, 32'h1014), 0, 0, 32'h0);
        repeat (3) @(negedge clk);

        // reset during the second WAIT cycle, then a stray ready pulse
        issue(mk(1, 0, 0, 4'hF, 32'h0, 32'h300, 1, 5'd12, 32'h1018), 0, 6, 32'h11112222);
        @(negedge clk);
        pulse_reset_begin();
        #1;
        check("rst_mid_ram_en", 32'(ram_en), 32'd0);
        check("rst_mid_stall_req", 32'(stall_req), 32'd0);
        check("rst_mid_wb_en", 32'(wb_reg_write_en), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1 ram_ready = 1'b1;
        #1;
        check("late_ready_ram_en", 32'(ram_en), 32'd0);
        check("late_ready_stall", 32'(stall_req), 32'd0);
        check("late_ready_wb_en", 32'(wb_reg_write_en), 32'd0);
        issue(mk(0, 0, 0, 4'h0, 32'h0, 32'hCAFEF00D, 1, 5'd13, 32'h101C), 0, 0, 32'h0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 2);
            case ($urandom_range(0, 2))
                0: sel = 4'h1;
                1: sel = 4'h3;
                default: sel = 4'hF;
            endcase
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sel == 4'hF) a[1:0] = 2'b00;
                if (sel == 4'h3) a[0] = 1'b0;
            end
            o = mk(kind == 1, kind == 2, 1'($urandom_range(0, 1)), sel, $urandom, a,
                   $urandom_range(0, 7) != 0, 5'($urandom_range(0, 31)), $urandom);
            issue(o, $urandom_range(0, 7) == 0, $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 4) == 0) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        check("wb_queue_drained", 32'(wbq.size()), 32'd0);
        check("ram_queue_drained", 32'(ramq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
